// File: rtl/fft_pmt_sched.sv
// fft_pmt_sched: detects frame starts on the radix-4 input stream and sequences
// the ctrl pulse and Gray-coded select of every downstream permutation stage.
module fft_pmt_sched #(
   parameter int PROBLEM_SIZE = 16,
   parameter int NUM_STAGES   = 2,
   parameter int STAGE_LAT    = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   input  logic                    in_sop,
   output logic [NUM_STAGES-1:0]   stage_ctrl,
   output logic [2*NUM_STAGES-1:0] stage_sel,
   output logic                    busy,
   output logic                    frame_done,
   output logic [15:0]             frame_cnt,
   output logic                    err_sop,
   output logic                    err_gap
);
   localparam int HOLD = PROBLEM_SIZE / 16;
   localparam int CPF  = PROBLEM_SIZE / 4;
   localparam int BW   = $clog2(CPF);
   localparam int HW   = (HOLD > 1) ? $clog2(HOLD) : 1;
   localparam int DLY  = (NUM_STAGES - 1) * STAGE_LAT;
   localparam int DW   = (DLY > 0) ? DLY : 1;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t                  r_state, w_state_nxt;
   logic [BW-1:0]           r_beat, w_beat_nxt;
   logic [DW-1:0]           r_dly;
   logic [NUM_STAGES-1:0]   r_act, w_act_nxt, r_ctrl, w_go, w_fin;
   logic [HW-1:0]           r_hold [NUM_STAGES];
   logic [HW-1:0]           w_hold_nxt [NUM_STAGES];
   logic [1:0]              r_step [NUM_STAGES];
   logic [1:0]              w_step_nxt [NUM_STAGES];
   logic [2*NUM_STAGES-1:0] r_sel, w_sel_nxt;
   logic                    w_sop, w_last, w_accept, w_pend;
   logic                    r_busy, r_done, r_err_sop, r_err_gap;
   logic [15:0]             r_cnt;

   assign w_sop    = in_valid & in_sop;
   assign w_last   = (r_beat == BW'(CPF - 1));
   assign w_accept = w_sop & ((r_state != RUN) | w_last);
   assign w_pend   = (DLY > 0) ? |r_dly : 1'b0;

   // stage k starts k*STAGE_LAT cycles after stage 0
   for (genvar k = 0; k < NUM_STAGES; k++) begin : g_go
      if (k == 0) begin : g_first
         assign w_go[k] = w_accept;
      end else begin : g_later
         assign w_go[k] = r_dly[k*STAGE_LAT-1];
      end
   end

   always_comb begin
      w_act_nxt = r_act;
      w_sel_nxt = '0;
      w_fin     = '0;
      for (int i = 0; i < NUM_STAGES; i++) begin
         w_hold_nxt[i] = r_hold[i];
         w_step_nxt[i] = r_step[i];
         w_fin[i]      = r_act[i] & (r_hold[i] == HW'(HOLD - 1)) & (r_step[i] == 2'd3);
         if (w_go[i]) begin
            w_act_nxt[i]  = 1'b1;
            w_hold_nxt[i] = '0;
            w_step_nxt[i] = '0;
         end else if (r_act[i]) begin
            w_hold_nxt[i] = (r_hold[i] == HW'(HOLD - 1)) ? '0 : r_hold[i] + HW'(1);
            if (r_hold[i] == HW'(HOLD - 1)) begin
               w_step_nxt[i] = r_step[i] + 2'd1;
               w_act_nxt[i]  = ~w_fin[i];
            end
         end
         w_sel_nxt[2*i +: 2] = {w_step_nxt[i][1], ^w_step_nxt[i]};
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_beat_nxt  = r_beat + BW'(1);
      if (w_accept) begin
         w_state_nxt = RUN;
         w_beat_nxt  = '0;
      end else if (r_state == RUN && w_last) begin
         w_state_nxt = DRAIN;
      end else if (r_state == DRAIN && !(|w_act_nxt) && !w_pend) begin
         w_state_nxt = IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= IDLE;
         r_beat    <= '0;
         r_dly     <= '0;
         r_act     <= '0;
         r_ctrl    <= '0;
         r_sel     <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_cnt     <= '0;
         r_err_sop <= 1'b0;
         r_err_gap <= 1'b0;
         for (int i = 0; i < NUM_STAGES; i++) begin
            r_hold[i] <= '0;
            r_step[i] <= '0;
         end
      end else begin
         r_state   <= w_state_nxt;
         r_beat    <= w_beat_nxt;
         r_dly     <= DW'({r_dly, w_accept});
         r_act     <= w_act_nxt;
         r_ctrl    <= w_go;
         r_sel     <= w_sel_nxt;
         r_busy    <= (w_state_nxt != IDLE) | (|w_act_nxt);
         r_done    <= w_fin[NUM_STAGES-1];
         r_cnt     <= r_cnt + 16'(w_fin[NUM_STAGES-1]);
         r_err_sop <= r_err_sop | ((r_state == RUN) & ~w_last & w_sop);
         r_err_gap <= r_err_gap | ((r_state == RUN) & ~w_last & ~in_valid);
         for (int i = 0; i < NUM_STAGES; i++) begin
            r_hold[i] <= w_hold_nxt[i];
            r_step[i] <= w_step_nxt[i];
         end
      end
   end

   assign stage_ctrl = r_ctrl;
   assign stage_sel  = r_sel;
   assign busy       = r_busy;
   assign frame_done = r_done;
   assign frame_cnt  = r_cnt;
   assign err_sop    = r_err_sop;
   assign err_gap    = r_err_gap;
endmodule

// File: tb/tb_fft_pmt_sched.sv
// tb_fft_pmt_sched: scoreboard bench; a default instance plus a PROBLEM_SIZE=64
// instance that only sees input once enabled.
module tb_fft_pmt_sched;
   localparam int NEVER = 1 << 30;

   logic clk = 1'b0, rst = 1'b0, in_valid = 1'b0, in_sop = 1'b0, en64 = 1'b0;
   logic v64, s64;
   logic [1:0] ctrl, ctrl64;
   logic [3:0] sel, sel64;
   logic busy, busy64, done, done64, es, eg, es64, eg64;
   logic [15:0] cnt, cnt64;

   assign v64 = in_valid & en64;
   assign s64 = in_sop & en64;

   always #5 clk = ~clk;

   fft_pmt_sched dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_sop(in_sop),
      .stage_ctrl(ctrl), .stage_sel(sel), .busy(busy), .frame_done(done),
      .frame_cnt(cnt), .err_sop(es), .err_gap(eg));

   fft_pmt_sched #(.PROBLEM_SIZE(64)) dut64 (
      .clk(clk), .rst(rst), .in_valid(v64), .in_sop(s64),
      .stage_ctrl(ctrl64), .stage_sel(sel64), .busy(busy64), .frame_done(done64),
      .frame_cnt(cnt64), .err_sop(es64), .err_gap(eg64));

   typedef struct {int s; int c;} ev_t;
   typedef struct {int lo; int hi;} iv_t;

   ev_t q_ctl[$];
   iv_t q_iv[$];
   int  q_dn[$], q_c64[$], q_dn64[$];
   int  cyc = 0, checks = 0, errors = 0, fc = 0, fc64 = 0;
   int  esop_c = NEVER, egap_c = NEVER, t64 = 0;
   int  t_s[2];
   bit  on_s[2];
   bit  on64 = 1'b0;

   always @(posedge clk) cyc = cyc + 1;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle=%0d got=%0d exp=%0d", nm, cyc, act, exp);
      end
   endtask

   function automatic int gray(input int i);
      return (i == 0) ? 0 : (i == 1) ? 1 : (i == 2) ? 3 : 2;
   endfunction

   task automatic drv(input logic v, input logic s);
      @(posedge clk);
      #1;
      in_valid = v;
      in_sop   = s;
   endtask

   task automatic idle(input int n);
      repeat (n) drv(1'b0, 1'b0);
   endtask

   task automatic beats(input int n);
      repeat (n) drv(1'b1, 1'b0);
   endtask

   // expected timing for a sop accepted in cycle c0 (CPF=4, STAGE_LAT=3)
   task automatic start_frame();
      drv(1'b1, 1'b1);
      q_ctl.push_back(ev_t'{0, cyc + 1});
      q_ctl.push_back(ev_t'{1, cyc + 4});
      q_dn.push_back(cyc + 8);
      q_iv.push_back(iv_t'{cyc + 1, cyc + 7});
      if (en64) begin
         q_c64.push_back(cyc + 1);
         q_dn64.push_back(cyc + 20);
      end
   endtask

   always @(negedge clk) begin
      int idx;
      int xb;
      if (!rst) begin
         chk("rst_ctrl", ctrl, 0);
         chk("rst_sel", sel, 0);
         chk("rst_busy", busy, 0);
         chk("rst_done", done, 0);
         chk("rst_cnt", cnt, 0);
         chk("rst_err", {es, eg}, 0);
         chk("rst_64", {ctrl64, sel64, done64, cnt64}, 0);
         on_s[0] = 1'b0;
         on_s[1] = 1'b0;
         on64    = 1'b0;
         fc      = 0;
         fc64    = 0;
      end else begin
         for (int k = 0; k < 2; k++) begin
            idx = -1;
            foreach (q_ctl[i]) if (q_ctl[i].s == k && q_ctl[i].c == cyc) idx = i;
            chk($sformatf("ctrl%0d", k), ctrl[k], int'(idx >= 0));
            if (idx >= 0) begin
               q_ctl.delete(idx);
               on_s[k] = 1'b1;
               t_s[k]  = 0;
            end
            chk($sformatf("sel%0d", k), sel[2*k +: 2], on_s[k] ? gray(t_s[k]) : 0);
            if (on_s[k]) begin
               t_s[k]++;
               on_s[k] = (t_s[k] < 4);
            end
         end
         xb = int'(q_dn.size() > 0 && q_dn[0] == cyc);
         chk("frame_done", done, xb);
         if (xb != 0) begin
            void'(q_dn.pop_front());
            fc++;
         end
         chk("frame_cnt", cnt, fc);
         xb = 0;
         foreach (q_iv[i]) if (q_iv[i].lo <= cyc && cyc <= q_iv[i].hi) xb = 1;
         chk("busy", busy, xb);
         chk("err_sop", es, int'(cyc >= esop_c));
         chk("err_gap", eg, int'(cyc >= egap_c));
         xb = int'(q_c64.size() > 0 && q_c64[0] == cyc);
         chk("ctrl0_64", ctrl64[0], xb);
         if (xb != 0) begin
            void'(q_c64.pop_front());
            on64 = 1'b1;
            t64  = 0;
         end
         chk("sel0_64", sel64[1:0], on64 ? gray(t64 / 4) : 0);
         if (on64) begin
            t64++;
            on64 = (t64 < 16);
         end
         xb = int'(q_dn64.size() > 0 && q_dn64[0] == cyc);
         chk("done_64", done64, xb);
         if (xb != 0) begin
            void'(q_dn64.pop_front());
            fc64++;
         end
         chk("cnt_64", cnt64, fc64);
      end
   end

   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      idle(2);
      start_frame(); beats(3); idle(10);
      start_frame(); beats(3); start_frame(); beats(3); idle(12);
      start_frame(); beats(1); drv(1'b1, 1'b1); esop_c = cyc + 1; beats(1); idle(10);
      start_frame(); beats(3); idle(1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      in_valid = 1'b0;
      in_sop = 1'b0;
      q_ctl.delete();
      q_dn.delete();
      q_iv.delete();
      q_c64.delete();
      q_dn64.delete();
      esop_c = NEVER;
      egap_c = NEVER;
      @(posedge clk);
      #1 rst = 1'b1;
      idle(2);
      start_frame(); beats(3); idle(10);
      start_frame(); beats(1); drv(1'b0, 1'b0); egap_c = cyc + 1; beats(1); idle(10);
      en64 = 1'b1;
      start_frame(); beats(15); idle(25);
      chk("left_ctl", q_ctl.size(), 0);
      chk("left_done", q_dn.size(), 0);
      chk("left_ctl64", q_c64.size(), 0);
      chk("left_done64", q_dn64.size(), 0);
      chk("cnt_final", cnt, 3);
      chk("cnt64_final", cnt64, 1);
      chk("err64_final", {es64, eg64}, 0);
      chk("err_final", {es, eg}, 1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
